// File: rtl/lane_broadcast_if.sv
// lane_bus_if: array of N_LANES lanes, WIDTH bits each.
// Modport P drives x; modport C reads it.
interface lane_bus_if #(
  parameter int N_LANES = 8,
  parameter int WIDTH   = 1
);
  logic [WIDTH-1:0] x [N_LANES-1:0];

  modport P (output x);
  modport C (input  x);
endinterface

// File: rtl/lane_broadcast.sv
// lane_broadcast: writes i_a to masked lanes of p.x, either all in one
// cycle (i_mode=0) or one lane per cycle (i_mode=1).
// Ports: i_clk, i_rst_n (sync, active-low), i_valid/o_ready handshake,
// i_a value, i_mask lane enables, i_mode, o_done pulse, p lane bus.
module lane_broadcast #(
  parameter int N_LANES = 8,
  parameter int WIDTH   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [N_LANES-1:0] i_mask,
  input  logic               i_mode,
  output logic               o_done,
  lane_bus_if.P              p
);

  localparam int IW = $clog2(N_LANES);
  localparam logic [IW-1:0] LAST = IW'(N_LANES - 1);

  typedef enum logic {
    IDLE,
    SERIAL
  } state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [WIDTH-1:0]   data;
  logic [N_LANES-1:0] mask;
  logic               accept;

  // Ready drops during reset so nothing is accepted while held.
  assign o_ready = (state == IDLE) && i_rst_n;
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      data   <= '0;
      mask   <= '0;
      o_done <= 1'b0;
      for (int k = 0; k < N_LANES; k++) begin
        p.x[k] <= '0;
      end
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!i_mode) begin
              for (int k = 0; k < N_LANES; k++) begin
                if (i_mask[k]) begin
                  p.x[k] <= i_a;
                end
              end
              o_done <= 1'b1;
            end else begin
              data  <= i_a;
              mask  <= i_mask;
              idx   <= '0;
              state <= SERIAL;
            end
          end
        end
        SERIAL: begin
          // Compare against each lane number so a non-power-of-2
          // lane count never indexes past the last lane.
          for (int k = 0; k < N_LANES; k++) begin
            if (idx == IW'(k) && mask[k]) begin
              p.x[k] <= data;
            end
          end
          if (idx == LAST) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_broadcast.sv
// tb_lane_broadcast: directed vectors for an 8-lane and a 5-lane
// instance, WIDTH=4, checked with immediate assertions.
module tb_lane_broadcast;

  logic       clk;
  logic       rst_n;

  logic       valid8, ready8, mode8, done8;
  logic [3:0] a8;
  logic [7:0] mask8;

  logic       valid5, ready5, mode5, done5;
  logic [3:0] a5;
  logic [4:0] mask5;

  logic [31:0] lanes8;
  logic [19:0] lanes5;
  logic [31:0] exp8;

  int vectors;
  int errs;

  lane_bus_if #(8, 4) bus8 ();
  lane_bus_if #(5, 4) bus5 ();

  lane_broadcast #(.N_LANES(8), .WIDTH(4)) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid8),
    .o_ready (ready8),
    .i_a     (a8),
    .i_mask  (mask8),
    .i_mode  (mode8),
    .o_done  (done8),
    .p       (bus8)
  );

  lane_broadcast #(.N_LANES(5), .WIDTH(4)) dut5 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid5),
    .o_ready (ready5),
    .i_a     (a5),
    .i_mask  (mask5),
    .i_mode  (mode5),
    .o_done  (done5),
    .p       (bus5)
  );

  always #5 clk = ~clk;

  always_comb begin
    lanes8 = '0;
    lanes5 = '0;
    for (int k = 0; k < 8; k++) lanes8[k*4 +: 4] = bus8.x[k];
    for (int k = 0; k < 5; k++) lanes5[k*4 +: 4] = bus5.x[k];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    clk     = 0;
    rst_n   = 0;
    valid8  = 1;
    a8      = 4'hF;
    mask8   = 8'hFF;
    mode8   = 0;
    valid5  = 0;
    a5      = 0;
    mask5   = 0;
    mode5   = 0;

    // 1. reset with valid held high
    tick();
    tick();
    chk("rst_lanes8", lanes8, 32'h0);
    chk("rst_lanes5", {12'h0, lanes5}, 32'h0);
    chk("rst_ready", {31'h0, ready8}, 32'h0);
    chk("rst_done", {31'h0, done8}, 32'h0);
    rst_n = 1;
    #1;
    chk("rel_ready", {31'h0, ready8}, 32'h1);

    // 2. broadcast, then masked broadcast back-to-back
    a8    = 4'hA;
    mask8 = 8'hFF;
    tick();
    chk("bc1_lanes", lanes8, 32'hAAAA_AAAA);
    chk("bc1_done", {31'h0, done8}, 32'h1);
    chk("bc1_ready", {31'h0, ready8}, 32'h1);
    a8    = 4'h3;
    mask8 = 8'h0F;
    tick();
    chk("bc2_lanes", lanes8, 32'hAAAA_3333);
    chk("bc2_done", {31'h0, done8}, 32'h1);
    valid8 = 0;
    tick();
    chk("bc_idle_done", {31'h0, done8}, 32'h0);
    chk("bc_idle_lanes", lanes8, 32'hAAAA_3333);

    // 3. serial, odd lanes only
    valid8 = 1;
    a8     = 4'h5;
    mask8  = 8'b1010_1010;
    mode8  = 1;
    tick();
    valid8 = 0;
    chk("ser_e0_lanes", lanes8, 32'hAAAA_3333);
    chk("ser_e0_ready", {31'h0, ready8}, 32'h0);
    chk("ser_e0_done", {31'h0, done8}, 32'h0);
    exp8 = 32'hAAAA_3333;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if ((k % 2) == 0) exp8[(k-1)*4 +: 4] = 4'h5;
      chk($sformatf("ser_lanes_e%0d", k), lanes8, exp8);
      chk($sformatf("ser_ready_e%0d", k), {31'h0, ready8},
          (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("ser_done_e%0d", k), {31'h0, done8},
          (k == 8) ? 32'h1 : 32'h0);
    end
    chk("ser_final", lanes8, 32'h5A5A_5353);

    // 4. back-pressure: broadcast of F held during a serial request
    valid8 = 1;
    a8     = 4'h2;
    mask8  = 8'h0F;
    mode8  = 1;
    tick();
    a8    = 4'hF;
    mask8 = 8'hFF;
    mode8 = 0;
    exp8  = 32'h5A5A_5353;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k <= 4) exp8[(k-1)*4 +: 4] = 4'h2;
      chk($sformatf("bp_lanes_e%0d", k), lanes8, exp8);
      chk($sformatf("bp_ready_e%0d", k), {31'h0, ready8},
          (k == 8) ? 32'h1 : 32'h0);
    end
    chk("bp_serial_done", {31'h0, done8}, 32'h1);
    chk("bp_serial_lanes", lanes8, 32'h5A5A_2222);
    tick();
    valid8 = 0;
    chk("bp_bc_lanes", lanes8, 32'hFFFF_FFFF);
    chk("bp_bc_done", {31'h0, done8}, 32'h1);
    tick();
    chk("bp_quiet_done", {31'h0, done8}, 32'h0);

    // 5. reset in the middle of a serial write
    valid8 = 1;
    a8     = 4'h7;
    mask8  = 8'hFF;
    mode8  = 1;
    tick();
    valid8 = 0;
    tick();
    tick();
    chk("mid_e2_lanes", lanes8, 32'hFFFF_FF77);
    rst_n = 0;
    tick();
    chk("mid_rst_lanes", lanes8, 32'h0);
    chk("mid_rst_done", {31'h0, done8}, 32'h0);
    chk("mid_rst_ready", {31'h0, ready8}, 32'h0);
    rst_n = 1;
    #1;
    chk("mid_rel_ready", {31'h0, ready8}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("mid_after_done%0d", k), {31'h0, done8}, 32'h0);
      chk($sformatf("mid_after_lanes%0d", k), lanes8, 32'h0);
    end

    // 6. five lanes: preload, then serial with empty mask
    valid5 = 1;
    a5     = 4'h9;
    mask5  = 5'h1F;
    mode5  = 0;
    tick();
    chk("n5_bc_lanes", {12'h0, lanes5}, 32'h0009_9999);
    chk("n5_bc_done", {31'h0, done5}, 32'h1);
    a5    = 4'hC;
    mask5 = 5'h00;
    mode5 = 1;
    tick();
    valid5 = 0;
    chk("n5_e0_ready", {31'h0, ready5}, 32'h0);
    chk("n5_e0_done", {31'h0, done5}, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("n5_lanes_e%0d", k), {12'h0, lanes5}, 32'h0009_9999);
      chk($sformatf("n5_done_e%0d", k), {31'h0, done5},
          (k == 5) ? 32'h1 : 32'h0);
      chk($sformatf("n5_ready_e%0d", k), {31'h0, ready5},
          (k == 5) ? 32'h1 : 32'h0);
      chk($sformatf("n5_idx_e%0d", k), {31'h0, (dut5.idx <= 3'd4)}, 32'h1);
    end
    tick();
    chk("n5_done_clear", {31'h0, done5}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
